cache_data_array_mw: RTL and testbench
======================================

Name: cache_data_array_mw

Overview:
- Parametrised multi-way cache data array: the next generation of the single-way 8-entry, 256-bit data store.
- Adds N ways, configurable set count, block and word width.
- Supports whole-block refill writes and byte-strobed word writes for store hits.
- Read is registered with one-cycle latency; a post-reset init sweep zeroes every entry.
- Sits beside the tag/valid array in the I/D cache. The cache FSM drives refill, store-hit and lookup traffic.

Parameters:
- WAYS, 2: number of ways, ≥2.
- SET_BITS, 3: set index width; sets = 2^SET_BITS.
- BLOCK_WIDTH, 256: bits per block.
- WORD_WIDTH, 32: bits per word; BLOCK_WIDTH/WORD_WIDTH must be a power of 2.
- Derived, not overridable:
  - WORDS = BLOCK_WIDTH/WORD_WIDTH
  - OFF_BITS = $clog2(WORDS)
  - WAY_BITS = $clog2(WAYS)

Ports:
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- init_done  out  1  high once the init sweep has finished; requests are accepted only while high.
- wen  in  1  write request.
- wway  in  WAY_BITS  target way.
- waddr  in  SET_BITS  target set.
- wmode  in  1  0 = whole block from wdata; 1 = single word from wword.
- woffset  in  OFF_BITS  word index within the block (wmode=1).
- wstrb  in  WORD_WIDTH/8  byte enables (wmode=1); bit i covers byte i of the word.
- wdata  in  BLOCK_WIDTH  block write data.
- wword  in  WORD_WIDTH  word write data.
- ren  in  1  read request.
- raddr  in  SET_BITS  read set.
- rdata  out  WAYS*BLOCK_WIDTH  all ways of the set; way k occupies bits [k*BLOCK_WIDTH +: BLOCK_WIDTH].
- rvalid  out  1  rdata is valid this cycle.

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=INIT, sweep counter=0
  - init_done=0, rvalid=0, rdata=0
- INIT state:
  - Each cycle, write zero to set[counter] in all ways, then increment counter.
  - After the cycle that clears set 2^SET_BITS-1, go to READY and set init_done=1 on the next edge.
  - The sweep takes exactly 2^SET_BITS cycles after reset release.
  - wen and ren are ignored in INIT; rvalid stays 0.
- READY state: terminal until the next reset.
- Reset asserted mid-sweep or mid-operation:
  - Immediate return to INIT with counter=0; any in-flight rvalid drops.
  - The sweep restarts from set 0 after release.
- Read:
  - ren=1 at edge T ⇒ at T+1 rdata = contents of all ways at raddr, and rvalid=1 for exactly one cycle.
  - Back-to-back ren gives one result per cycle.
  - While ren=0, rvalid=0 and rdata holds its last value.
- Block write (wen=1, wmode=0): array[wway][waddr] <= wdata.
- Word write (wen=1, wmode=1):
  - Only bytes j with wstrb[j]=1 of word woffset in array[wway][waddr] take the corresponding bytes of wword.
  - All other bytes and words are unchanged.
  - wstrb=0 is a legal no-op.
- Out-of-range way: if wway ≥ WAYS (WAYS not a power of 2), the write is dropped; no other way is modified.
- Simultaneous read and write, same set, without the optional feature: read-before-write; rdata at T+1 shows the pre-write contents.
- Different sets: fully independent, both complete in the same cycle.
- Storage: plain registers, no reset on array contents; the sweep provides the known initial state.

Optional Feature:
- Macro: DARRAY_WR_BYPASS_EN.
- Defined: a same-cycle read and write to the same set forwards the new data.
  - The targeted way's slice of rdata at T+1 equals the post-write block, with word-write byte merging applied.
  - Other ways show stored data.
- Undefined: read-before-write as above; no forwarding logic is built.

Test Plan:
- Reset, then release: init_done rises exactly 8 cycles later (SET_BITS=3); a read of every set returns all zeros in both ways; ren asserted during INIT gives no rvalid.
- Block write way 1, set 5, 0xA5…A5, then ren set 5: at T+1 rvalid=1, way1 slice = 0xA5…A5, way0 slice = 0.
- Word write way 0, set 2, woffset=3, wword=0x11223344, wstrb=4'b0101, over a block of zeros: word3 = 0x00220044, all other words 0.
- Same-cycle wen/ren on set 4 way 0 with wdata=0xFF…FF over an old value of 0:
  - macro off ⇒ rdata way0 = 0.
  - macro on ⇒ way0 = 0xFF…FF.
  - A following read returns 0xFF…FF in both builds.
- Pulse resetn low at sweep cycle 4: init_done stays 0, the sweep restarts, and init_done rises 8 cycles after the second release.
- Back-to-back ren on sets 0,1,2 with distinct data written earlier: rvalid high for 3 consecutive cycles with rdata in order; rdata holds the set-2 data after ren drops.

Source files
------------

// File: rtl/cache_data_array_mw.sv
// Multi-way cache data array: registered all-way read, block refill and byte-strobed word writes,
// post-reset zeroing sweep. Define DARRAY_WR_BYPASS_EN to forward same-set writes onto the read port.
module cache_data_array_mw #(
    parameter  int WAYS        = 2,
    parameter  int SET_BITS    = 3,
    parameter  int BLOCK_WIDTH = 256,
    parameter  int WORD_WIDTH  = 32,
    localparam int WORDS       = BLOCK_WIDTH / WORD_WIDTH,
    localparam int OFF_BITS    = $clog2(WORDS),
    localparam int WAY_BITS    = $clog2(WAYS),
    localparam int BYTES       = WORD_WIDTH / 8
) (
    input  logic                        clk,
    input  logic                        resetn,
    output logic                        init_done,
    input  logic                        wen,
    input  logic [WAY_BITS-1:0]         wway,
    input  logic [SET_BITS-1:0]         waddr,
    input  logic                        wmode,
    input  logic [OFF_BITS-1:0]         woffset,
    input  logic [BYTES-1:0]            wstrb,
    input  logic [BLOCK_WIDTH-1:0]      wdata,
    input  logic [WORD_WIDTH-1:0]       wword,
    input  logic                        ren,
    input  logic [SET_BITS-1:0]         raddr,
    output logic [WAYS*BLOCK_WIDTH-1:0] rdata,
    output logic                        rvalid
);

    // state    | meaning
    // ST_INIT  | zeroing one set per cycle in all ways; requests ignored
    // ST_READY | sweep complete; reads and writes accepted until next reset
    typedef enum logic {ST_INIT, ST_READY} state_t;

    localparam int SETS = 1 << SET_BITS;

    state_t                     state_q, state_d;
    logic [SET_BITS-1:0]        sweep_cnt;
    logic                       sweep_last;
    logic                       sweeping;
    logic                       wr_go;
    logic                       rd_go;
    logic [WAYS*BLOCK_WIDTH-1:0] rd_next;

    assign sweep_last = (sweep_cnt == {SET_BITS{1'b1}});
    assign sweeping   = (state_q == ST_INIT);
    assign init_done  = (state_q == ST_READY);
    assign wr_go      = init_done && wen;
    assign rd_go      = init_done && ren;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  if (sweep_last) state_d = ST_READY;
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sweep_cnt <= '0;
        end else if (sweeping) begin
            sweep_cnt <= sweep_cnt + 1'b1;
        end
    end

    // One storage bank per way; a way index beyond WAYS never matches any bank, so the write is dropped.
    for (genvar k = 0; k < WAYS; k++) begin : gen_way
        logic [BLOCK_WIDTH-1:0] mem [SETS];
        logic [BLOCK_WIDTH-1:0] cur_blk;
        logic [BLOCK_WIDTH-1:0] merged;
        logic [BLOCK_WIDTH-1:0] new_blk;
        logic                   sel;

        assign sel = wr_go && (wway == WAY_BITS'(k));

        always_comb begin
            cur_blk = mem[waddr];
            merged  = cur_blk;
            for (int w = 0; w < WORDS; w++) begin
                for (int j = 0; j < BYTES; j++) begin
                    if ((woffset == OFF_BITS'(w)) && wstrb[j]) begin
                        merged[w*WORD_WIDTH + j*8 +: 8] = wword[j*8 +: 8];
                    end
                end
            end
            new_blk = wmode ? merged : wdata;
        end

        always_ff @(posedge clk) begin
            if (sweeping) begin
                mem[sweep_cnt] <= '0;
            end else if (sel) begin
                mem[waddr] <= new_blk;
            end
        end

`ifdef DARRAY_WR_BYPASS_EN
        assign rd_next[k*BLOCK_WIDTH +: BLOCK_WIDTH] =
            (sel && (waddr == raddr)) ? new_blk : mem[raddr];
`else
        assign rd_next[k*BLOCK_WIDTH +: BLOCK_WIDTH] = mem[raddr];
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= rd_go;
            if (rd_go) begin
                rdata <= rd_next;
            end
        end
    end

endmodule

// File: tb/tb_cache_data_array_mw.sv
// Scoreboard bench for cache_data_array_mw: stimulus pushes expected read data, a negedge monitor pops and compares.
module tb_cache_data_array_mw;

    localparam int BW = 256;
    localparam int RW = 2 * BW;

    logic          clk;
    logic          resetn;
    logic          init_done;
    logic          wen;
    logic [0:0]    wway;
    logic [2:0]    waddr;
    logic          wmode;
    logic [2:0]    woffset;
    logic [3:0]    wstrb;
    logic [BW-1:0] wdata;
    logic [31:0]   wword;
    logic          ren;
    logic [2:0]    raddr;
    logic [RW-1:0] rdata;
    logic          rvalid;

    int n_pass  = 0;
    int n_total = 0;
    logic [RW-1:0] exp_q [$];

    cache_data_array_mw dut (
        .clk       (clk),
        .resetn    (resetn),
        .init_done (init_done),
        .wen       (wen),
        .wway      (wway),
        .waddr     (waddr),
        .wmode     (wmode),
        .woffset   (woffset),
        .wstrb     (wstrb),
        .wdata     (wdata),
        .wword     (wword),
        .ren       (ren),
        .raddr     (raddr),
        .rdata     (rdata),
        .rvalid    (rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (resetn && rvalid) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_rvalid: got rvalid=1 required no pending read");
            end else begin
                check("rdata", rdata, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_blk(input logic way, input logic [2:0] set, input logic [BW-1:0] d);
        wen = 1'b1; wmode = 1'b0; wway = way; waddr = set; wdata = d;
        tick();
        wen = 1'b0;
    endtask

    task automatic wr_word(input logic way, input logic [2:0] set, input logic [2:0] off,
                           input logic [3:0] strb, input logic [31:0] w);
        wen = 1'b1; wmode = 1'b1; wway = way; waddr = set; woffset = off; wstrb = strb; wword = w;
        tick();
        wen = 1'b0;
    endtask

    task automatic rd(input logic [2:0] set, input logic [RW-1:0] exp);
        ren = 1'b1; raddr = set;
        exp_q.push_back(exp);
        tick();
        ren = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] a5, ff, w3, d0, d1, d2, a5w;
        a5 = {32{8'hA5}};
        ff = '1;
        w3 = '0; w3[127:96] = 32'h0022_0044;
        d0 = {8{32'h1111_0000}};
        d1 = {8{32'h2222_3333}};
        d2 = {8{32'h4444_5555}};
        a5w = a5; a5w[31:0] = 32'hDEAD_BEEF;

        resetn = 1'b0; wen = 1'b0; wway = '0; waddr = '0; wmode = 1'b0; woffset = '0;
        wstrb = '0; wdata = '0; wword = '0; ren = 1'b1; raddr = '0;
        repeat (3) tick();
        check("reset_rvalid", RW'(rvalid), RW'(1'b0));
        check("reset_init_done", RW'(init_done), RW'(1'b0));
        check("reset_rdata", rdata, '0);

        // ren held high through the whole sweep must produce nothing
        resetn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("init_done_c%0d", i), RW'(init_done), RW'(i == 8));
            check($sformatf("init_rvalid_c%0d", i), RW'(rvalid), RW'(1'b0));
        end
        ren = 1'b0;

        for (int s = 0; s < 8; s++) rd(3'(s), '0);
        repeat (2) tick();

        wr_blk(1'b1, 3'd5, a5);
        rd(3'd5, {a5, {BW{1'b0}}});

        wr_word(1'b0, 3'd2, 3'd3, 4'b0101, 32'h1122_3344);
        rd(3'd2, {{BW{1'b0}}, w3});
        wr_word(1'b0, 3'd2, 3'd3, 4'b0000, 32'hFFFF_FFFF);
        rd(3'd2, {{BW{1'b0}}, w3});
        wr_word(1'b1, 3'd5, 3'd0, 4'b1111, 32'hDEAD_BEEF);
        rd(3'd5, {a5w, {BW{1'b0}}});

        wen = 1'b1; wmode = 1'b0; wway = 1'b0; waddr = 3'd4; wdata = ff;
        ren = 1'b1; raddr = 3'd4;
`ifdef DARRAY_WR_BYPASS_EN
        exp_q.push_back({{BW{1'b0}}, ff});
`else
        exp_q.push_back({RW{1'b0}});
`endif
        tick();
        wen = 1'b0; ren = 1'b0;
        rd(3'd4, {{BW{1'b0}}, ff});

        wr_blk(1'b0, 3'd0, d0);
        wr_blk(1'b1, 3'd1, d1);
        wr_blk(1'b0, 3'd2, d2);
        ren = 1'b1; raddr = 3'd0; exp_q.push_back({{BW{1'b0}}, d0});
        tick();
        check("b2b_rvalid_0", RW'(rvalid), RW'(1'b1));
        raddr = 3'd1; exp_q.push_back({d1, {BW{1'b0}}});
        tick();
        check("b2b_rvalid_1", RW'(rvalid), RW'(1'b1));
        raddr = 3'd2; exp_q.push_back({{BW{1'b0}}, d2});
        tick();
        check("b2b_rvalid_2", RW'(rvalid), RW'(1'b1));
        ren = 1'b0;
        tick();
        check("idle_rvalid", RW'(rvalid), RW'(1'b0));
        check("idle_rdata_hold", rdata, {{BW{1'b0}}, d2});
        tick();
        check("idle_rdata_hold2", rdata, {{BW{1'b0}}, d2});

        // reset lands while a read result is on the port, before the monitor samples it
        ren = 1'b1; raddr = 3'd5;
        tick();
        check("inflight_rvalid", RW'(rvalid), RW'(1'b1));
        ren = 1'b0;
        resetn = 1'b0;
        #1;
        check("midop_rvalid", RW'(rvalid), RW'(1'b0));
        check("midop_rdata", rdata, '0);
        check("midop_init_done", RW'(init_done), RW'(1'b0));
        tick();
        resetn = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("sweep1_init_done_c%0d", i), RW'(init_done), RW'(1'b0));
        end
        resetn = 1'b0;
        #1;
        check("pulse_init_done", RW'(init_done), RW'(1'b0));
        tick();
        resetn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("sweep2_init_done_c%0d", i), RW'(init_done), RW'(i == 8));
        end

        rd(3'd5, '0);
        rd(3'd4, '0);
        rd(3'd0, '0);
        repeat (3) tick();
        check("scoreboard_drained", RW'(exp_q.size()), RW'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
